hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed 3-bit, two-source address-match hazard check.
- Keeps its own shift-register scoreboard of in-flight destination writes, one entry per pipeline stage after decode, and raises a decode-stage stall from that scoreboard.
- Supports N source operands, configurable address width and depth, an optional register-file write-through exemption, and a forwarding mode that stalls only on load-use.
- Sits in ID and drives the IF/ID hold and ID/EX bubble.

---
 rtl/hazard_scoreboard.sv | 81 ++++++++
 tb/tb_hazard_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: a shift-register scoreboard of in-flight
// destination writes, with optional RF write-through exemption and load-use-only mode.
module hazard_scoreboard #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned RF_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic [ADDR_W-1:0]         id_dst_addr,
  input  logic                      id_dst_we,
  input  logic                      id_is_load,
  input  logic                      fwd_en,
  input  logic                      flush,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]  ent_v;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  // Only the EX-stage load flag is ever consulted, so older stages drop it.
  logic              ex_ld;

  logic hit_any;
  logic hit_ld;
  logic match;

  // Hazard detection against the current scoreboard contents.
  always_comb begin
    hit_any = 1'b0;
    hit_ld  = 1'b0;
    match   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        match = id_src_use[i] & ent_v[k] &
                (id_src_addr[i*ADDR_W +: ADDR_W] == ent_addr[k]);
        if (match && !((RF_BYPASS != 0) && (k == DEPTH - 1))) begin
          hit_any = 1'b1;
        end
        if (match && (k == 0) && ex_ld) begin
          hit_ld = 1'b1;
        end
      end
    end
    stall = id_valid & (fwd_en ? hit_ld : hit_any);
  end

  assign busy = |ent_v;

  // Unconditional shift; a stall or flush enters a bubble, flush also kills younger stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_v     <= '0;
      ex_ld     <= 1'b0;
      stall_cnt <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_addr[k] <= '0;
      end
    end else begin
      ent_v[0]    <= id_valid & id_dst_we & ~stall & ~flush;
      ent_addr[0] <= id_dst_addr;
      ex_ld       <= id_is_load;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        ent_v[k]    <= ent_v[k-1] & (~flush | (k == DEPTH - 1));
        ent_addr[k] <= ent_addr[k-1];
      end
      if (stall && !flush && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three parameter variants share one stimulus
// stream and are checked each cycle against an age-tagged producer-list model.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int BYP  [3] = '{1, 0, 1};
  localparam int CMAX [3] = '{65535, 65535, 15};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] id_src_addr = '0;
  logic [1:0] id_src_use = '0;
  logic [2:0] id_dst_addr = '0;
  logic       id_dst_we = 1'b0;
  logic       id_is_load = 1'b0;
  logic       fwd_en = 1'b0;
  logic       flush = 1'b0;

  logic        stall0, stall1, stall2;
  logic        busy0, busy1, busy2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_use(id_src_use), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .fwd_en(fwd_en), .flush(flush),
    .stall(stall0), .stall_cnt(cnt0), .busy(busy0));

  hazard_scoreboard #(.RF_BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_use(id_src_use), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .fwd_en(fwd_en), .flush(flush),
    .stall(stall1), .stall_cnt(cnt1), .busy(busy1));

  hazard_scoreboard #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_use(id_src_use), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .fwd_en(fwd_en), .flush(flush),
    .stall(stall2), .stall_cnt(cnt2), .busy(busy2));

  // Model: list of in-flight producers, each tagged with its age (0 = EX).
  typedef struct packed {
    logic       live;
    logic [2:0] addr;
    logic       ld;
    logic [3:0] age;
  } rec_t;

  rec_t recs [3][4];
  int   mcnt [3];

  function automatic logic model_stall(input int m);
    if (!rst || !id_valid) return 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (recs[m][s].live) begin
        for (int i = 0; i < 2; i++) begin
          if (id_src_use[i] && (id_src_addr[i*3 +: 3] == recs[m][s].addr)) begin
            if (fwd_en) begin
              if (recs[m][s].age == 4'd0 && recs[m][s].ld) return 1'b1;
            end else if (!(BYP[m] != 0 && int'(recs[m][s].age) == DEPTH - 1)) begin
              return 1'b1;
            end
          end
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic logic model_busy(input int m);
    for (int s = 0; s < 4; s++) if (recs[m][s].live) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 3; m++) begin
        mcnt[m] = 0;
        for (int s = 0; s < 4; s++) recs[m][s] = '0;
      end
    end else begin
      for (int m = 0; m < 3; m++) begin
        logic st;
        logic placed;
        st = model_stall(m);
        if (st && !flush && mcnt[m] < CMAX[m]) mcnt[m]++;
        for (int s = 0; s < 4; s++) begin
          if (recs[m][s].live) begin
            recs[m][s].age = recs[m][s].age + 4'd1;
            if (int'(recs[m][s].age) >= DEPTH) recs[m][s].live = 1'b0;
            else if (flush && int'(recs[m][s].age) < DEPTH - 1) recs[m][s].live = 1'b0;
          end
        end
        placed = 1'b0;
        if (!flush && id_valid && id_dst_we && !st) begin
          for (int s = 0; s < 4; s++) begin
            if (!placed && !recs[m][s].live) begin
              recs[m][s] = '{live: 1'b1, addr: id_dst_addr, ld: id_is_load, age: 4'd0};
              placed = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("stall0", 32'(stall0), 32'(model_stall(0)));
    chk("stall1", 32'(stall1), 32'(model_stall(1)));
    chk("stall2", 32'(stall2), 32'(model_stall(2)));
    chk("busy0", 32'(busy0), 32'(model_busy(0)));
    chk("busy1", 32'(busy1), 32'(model_busy(1)));
    chk("busy2", 32'(busy2), 32'(model_busy(2)));
    chk("cnt0", 32'(cnt0), 32'(mcnt[0]));
    chk("cnt1", 32'(cnt1), 32'(mcnt[1]));
    chk("cnt2", 32'(cnt2), 32'(mcnt[2]));
  end

  task automatic drive(input logic v, input logic we, input logic [2:0] dst,
                       input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] su, input logic ld);
    id_valid    = v;
    id_dst_we   = we;
    id_dst_addr = dst;
    id_src_addr = {s1, s0};
    id_src_use  = su;
    id_is_load  = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0);
    repeat (DEPTH) step();
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Producer r5, then consumer of r5 without forwarding.
    drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 2'b11, 1'b0);
    step();
    chk("ins_busy", 32'(busy0), 32'd1);
    chk("ins_nostall", 32'(stall0), 32'd0);
    drive(1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01, 1'b0);
    #1 chk("raw_c0", 32'(stall0), 32'd1);
    step();
    chk("raw_c1", 32'(stall0), 32'd1);
    step();
    chk("raw_c2_byp", 32'(stall0), 32'd0);
    chk("raw_c2_nobyp", 32'(stall1), 32'd1);
    chk("raw_cnt", 32'(cnt0), 32'd2);
    drain();

    // Forwarding: non-load producer never stalls, load producer stalls one cycle.
    fwd_en = 1'b1;
    drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 2'b11, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01, 1'b0);
    #1 chk("fwd_alu_c0", 32'(stall0), 32'd0);
    step();
    chk("fwd_alu_c1", 32'(stall0), 32'd0);
    drain();
    drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 2'b11, 1'b1);
    step();
    drive(1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01, 1'b0);
    #1 chk("fwd_ld_c0", 32'(stall0), 32'd1);
    step();
    chk("fwd_ld_c1", 32'(stall0), 32'd0);
    chk("fwd_ld_cnt", 32'(cnt0), 32'd3);
    drain();
    fwd_en = 1'b0;

    // Matches that must not stall: source unused, decode not valid.
    drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 2'b11, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'd0, 3'd5, 3'd5, 2'b00, 1'b0);
    #1 chk("nouse", 32'(stall0), 32'd0);
    drive(1'b0, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01, 1'b0);
    #1 chk("novalid", 32'(stall0), 32'd0);
    drain();

    // Flush during a stall clears the young entries and does not count.
    drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 2'b11, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 2'b01, 1'b0);
    #1 chk("pre_flush", 32'(stall0), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_stall", 32'(stall0), 32'd0);
    chk("flush_busy", 32'(busy0), 32'd0);
    chk("flush_cnt", 32'(cnt0), 32'd3);
    drain();

    // Duplicate sources give one stall per cycle.
    drive(1'b1, 1'b1, 3'd5, 3'd1, 3'd2, 2'b11, 1'b0);
    step();
    drive(1'b1, 1'b0, 3'd0, 3'd5, 3'd5, 2'b11, 1'b0);
    step();
    step();
    chk("dup_stall", 32'(stall0), 32'd0);
    chk("dup_cnt", 32'(cnt0), 32'd5);
    drain();

    // Self read/write r5 repeatedly: stalls 2 of every 3 cycles, 20 in 31 edges.
    drive(1'b1, 1'b1, 3'd5, 3'd5, 3'd0, 2'b01, 1'b0);
    repeat (31) step();
    chk("sat_stall", 32'(stall0), 32'd1);
    chk("sat_cnt16", 32'(cnt0), 32'd25);
    chk("sat_cnt4", 32'(cnt2), 32'd15);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall0), 32'd0);
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    chk("rst_mid_cnt", 32'(cnt0), 32'd0);
    chk("rst_mid_cnt4", 32'(cnt2), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_stall", 32'(stall0), 32'd0);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    step();
    chk("post_rst_ins", 32'(busy0), 32'd1);
    drain();
    step();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
